mem_arbiter: RTL

Two-port arbiter that shares one single-port synchronous `memory` instance between the CPU's instruction-fetch path and its data path. It lets the CPU run from a unified instruction/data memory instead of separate blocks. Each cycle it picks at most one access, using round-robin on contention. It routes the one-cycle-late read data back to the owner and keeps saturating contention statistics for the debug `$display` trace.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous memory between the CPU fetch path and
//   data path. At most one access is granted per cycle. When both paths
//   request, round-robin alternates the winner. Read data returns one cycle
//   after the grant, routed to the port that owned the read. Two saturating
//   counters record contention statistics for debug tracing.
//
// Ports
//   clk, rst_n             system clock, synchronous active-low reset
//   if_req/if_addr         fetch request, held until if_gnt
//   if_gnt                 fetch accepted this cycle
//   if_valid/if_rdata      fetch read return, one cycle after if_gnt
//   dm_req/dm_we/dm_addr/dm_wdata
//                          data request, held until dm_gnt
//   dm_gnt                 data accepted this cycle
//   dm_valid/dm_rdata      data read return, one cycle after a read grant
//   mem_addr/mem_wdata/mem_we
//                          memory request side
//   mem_rdata              memory read data, valid the cycle after its address
//   stat_conflicts         cycles with both requests high
//   stat_if_stalls         cycles with if_req high and if_gnt low
//
// Read-owner state (rd_own)
//   state    | meaning
//   OWN_NONE | no read return expected this cycle
//   OWN_IF   | mem_rdata belongs to the fetch port
//   OWN_DM   | mem_rdata belongs to the data port
module mem_arbiter #(
    parameter int N  = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [N-1:0]  if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [N-1:0]  if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [N-1:0]  dm_addr,
    input  logic [N-1:0]  dm_wdata,
    output logic          dm_gnt,
    output logic          dm_valid,
    output logic [N-1:0]  dm_rdata,
    output logic [N-1:0]  mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [N-1:0]  mem_rdata,
    output logic [CW-1:0] stat_conflicts,
    output logic [CW-1:0] stat_if_stalls
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } own_t;

    // last_q: 0 = fetch won the previous contention, 1 = data won it
    logic          last_q, last_d;
    own_t          rd_own_q, rd_own_d;
    logic [CW-1:0] conflicts_q, conflicts_d;
    logic [CW-1:0] if_stalls_q, if_stalls_d;

    logic both_req;
    logic grant_if;
    logic grant_dm;

    always_comb begin
        both_req = if_req & dm_req;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (rst_n) begin
            if (both_req) begin
                // The loser of the previous contention wins this one.
                grant_if = last_q;
                grant_dm = ~last_q;
            end else begin
                grant_if = if_req;
                grant_dm = dm_req;
            end
        end

        last_d = last_q;
        if (both_req) begin
            last_d = grant_dm;
        end

        rd_own_d = OWN_NONE;
        if (grant_if) begin
            rd_own_d = OWN_IF;
        end else if (grant_dm && !dm_we) begin
            rd_own_d = OWN_DM;
        end

        conflicts_d = conflicts_q;
        if (both_req && (conflicts_q != {CW{1'b1}})) begin
            conflicts_d = conflicts_q + CW'(1);
        end

        if_stalls_d = if_stalls_q;
        if (if_req && !grant_if && (if_stalls_q != {CW{1'b1}})) begin
            if_stalls_d = if_stalls_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            rd_own_q    <= OWN_NONE;
            conflicts_q <= '0;
            if_stalls_q <= '0;
        end else begin
            last_q      <= last_d;
            rd_own_q    <= rd_own_d;
            conflicts_q <= conflicts_d;
            if_stalls_q <= if_stalls_d;
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign mem_addr  = grant_dm ? dm_addr : if_addr;
    assign mem_wdata = dm_wdata;
    assign mem_we    = grant_dm & dm_we;

    // Gating with rst_n suppresses the return of a read granted just before reset.
    assign if_valid  = rst_n & (rd_own_q == OWN_IF);
    assign dm_valid  = rst_n & (rd_own_q == OWN_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

    assign stat_conflicts = conflicts_q;
    assign stat_if_stalls = if_stalls_q;

endmodule
